// File: rtl/router_port_reader_if.sv
// Port-side bus of one router output-port reader: FIFO handshake, payload stream,
// packet status and counters.
interface router_port_reader_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
);
  logic              enable;
  logic [4:0]        rd_delay;
  logic              vld_out;
  logic              soft_reset;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] byte_out;
  logic              byte_valid;
  logic [5:0]        pkt_len;
  logic              pkt_done;
  logic              parity_err;
  logic              busy;
  logic [CNT_W-1:0]  pkt_count;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  drop_count;

  modport master (
    input  enable, rd_delay, vld_out, soft_reset, data_in,
    output rd_en, byte_out, byte_valid, pkt_len, pkt_done, parity_err, busy,
           pkt_count, err_count, drop_count
  );

  modport slave (
    output enable, rd_delay, vld_out, soft_reset, data_in,
    input  rd_en, byte_out, byte_valid, pkt_len, pkt_done, parity_err, busy,
           pkt_count, err_count, drop_count
  );
endinterface

// File: rtl/router_port_reader.sv
// Destination-side reader for one router output port: drains a packet from the port
// FIFO, streams its payload, checks parity and keeps saturating packet counters.
module router_port_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input logic                  clk,
  input logic                  rst,
  router_port_reader_if.master port
);

  localparam int unsigned LEN_W  = 6;
  localparam int unsigned LEFT_W = 7;
  localparam int unsigned DLY_W  = 5;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DELAY   = 3'd1;
  localparam logic [2:0] HDR_RD  = 3'd2;
  localparam logic [2:0] HDR_CAP = 3'd3;
  localparam logic [2:0] PAY_RD  = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]        state, state_next;
  logic [DLY_W-1:0]  dly_cnt;
  logic [LEFT_W-1:0] reads_left;
  logic [LEN_W-1:0]  pay_cnt, pkt_len, hdr_len;
  logic [DATA_W-1:0] parity_acc, byte_out;
  logic              cap, byte_valid, pkt_done, parity_err, busy;
  logic [CNT_W-1:0]  pkt_count, err_count, drop_count;
  logic              rd_en_c, drop, cap_ok, pay_last, par_mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // A zero length field is read as a one-byte packet.
  assign hdr_len = (port.data_in[7:2] == '0) ? LEN_W'(1) : port.data_in[7:2];

  always_comb begin
    state_next   = state;
    drop         = port.soft_reset && (state != IDLE) && (state != DONE);
    rd_en_c      = ((state == HDR_RD) || (state == PAY_RD)) && port.vld_out &&
                   (reads_left != '0) && !port.soft_reset;
    cap_ok       = cap && !drop;
    pay_last     = (state == PAY_RD) && cap_ok && (pay_cnt == pkt_len);
    par_mismatch = (port.data_in != parity_acc);
    case (state)
      IDLE:    if (port.vld_out && port.enable) state_next = DELAY;
      DELAY:   if (dly_cnt == '0) state_next = HDR_RD;
      HDR_RD:  if (rd_en_c) state_next = HDR_CAP;
      HDR_CAP: state_next = PAY_RD;
      PAY_RD:  if (pay_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (drop) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap        <= 1'b0;
      dly_cnt    <= '0;
      reads_left <= '0;
      pay_cnt    <= '0;
      pkt_len    <= '0;
      parity_acc <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
      pkt_count  <= '0;
      err_count  <= '0;
      drop_count <= '0;
    end else begin
      cap        <= rd_en_c;
      byte_valid <= 1'b0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      busy       <= (state_next != IDLE);

      if (state == IDLE)        dly_cnt <= port.rd_delay;
      else if (dly_cnt != '0)   dly_cnt <= dly_cnt - DLY_W'(1);

      // One header read, then payload plus parity byte.
      if (state == DELAY)        reads_left <= LEFT_W'(1);
      else if (state == HDR_CAP) reads_left <= LEFT_W'(hdr_len) + LEFT_W'(1);
      else if (rd_en_c)          reads_left <= reads_left - LEFT_W'(1);

      if (drop) drop_count <= sat_inc(drop_count);

      if ((state == HDR_CAP) && cap_ok) begin
        pkt_len    <= hdr_len;
        parity_acc <= port.data_in;
        pay_cnt    <= '0;
      end

      if ((state == PAY_RD) && cap_ok) begin
        if (pay_cnt != pkt_len) begin
          byte_out   <= port.data_in;
          byte_valid <= 1'b1;
          parity_acc <= parity_acc ^ port.data_in;
          pay_cnt    <= pay_cnt + LEN_W'(1);
        end else begin
          pkt_done   <= 1'b1;
          parity_err <= par_mismatch;
          pkt_count  <= sat_inc(pkt_count);
          if (par_mismatch) err_count <= sat_inc(err_count);
        end
      end
    end
  end

  assign port.rd_en      = rd_en_c;
  assign port.byte_out   = byte_out;
  assign port.byte_valid = byte_valid;
  assign port.pkt_len    = pkt_len;
  assign port.pkt_done   = pkt_done;
  assign port.parity_err = parity_err;
  assign port.busy       = busy;
  assign port.pkt_count  = pkt_count;
  assign port.err_count  = err_count;
  assign port.drop_count = drop_count;

endmodule

// File: tb/tb_router_port_reader.sv
// Bench for router_port_reader: a queue-based FIFO model feeds packets, and payload,
// status and counters are compared against a packet-level reference model.
module tb_router_port_reader;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  router_port_reader_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) p ();
  router_port_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .port(p));

  int n_assert = 0;
  int n_fail = 0;
  int unsigned cyc = 0;
  logic [7:0] fifo[$];
  logic [7:0] pay_q[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] got[$];
  int exp_sizes[$];
  int done_sizes[$];
  bit exp_perr[$];
  bit done_perr[$];
  int unsigned done_cyc[$];
  int unsigned rd_cyc[$];
  int unsigned vld_rise_cyc = 0;
  int reads = 0;
  int rd_viol = 0;
  int stray_perr = 0;
  int stall_at = -1;
  int stall_left = 0;
  bit rand_stall = 1'b0;
  int exp_pkt = 0;
  int exp_err = 0;
  int exp_drop = 0;

  initial forever @(posedge clk) cyc++;

  // FIFO model: data appears the cycle after a sampled rd_en; inputs change on negedge.
  initial begin : fifo_model
    bit pop_pending;
    bit stalled;
    bit vld_now;
    pop_pending = 1'b0;
    p.vld_out = 1'b0;
    p.data_in = '0;
    forever begin
      @(negedge clk);
      if (pop_pending && fifo.size() != 0) p.data_in = fifo.pop_front();
      stalled = (stall_left > 0);
      if (stalled) stall_left--;
      vld_now = (fifo.size() != 0) && !stalled && !(rand_stall && $urandom_range(0, 3) == 0);
      if (vld_now && !p.vld_out) vld_rise_cyc = cyc;
      p.vld_out = vld_now;
      #1;
      pop_pending = (p.rd_en === 1'b1);
      if (p.rd_en === 1'b1) begin
        if (p.vld_out !== 1'b1) rd_viol++;
        reads++;
        rd_cyc.push_back(cyc);
        if (reads == stall_at) stall_left = 4;
      end
    end
  end

  initial begin : out_monitor
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (p.byte_valid === 1'b1) got.push_back(p.byte_out);
        if (p.pkt_done === 1'b1) begin
          done_sizes.push_back(got.size());
          done_perr.push_back(p.parity_err === 1'b1);
          done_cyc.push_back(cyc);
        end else if (p.parity_err !== 1'b0) begin
          stray_perr++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic clear_obs();
    got.delete(); exp_bytes.delete(); exp_sizes.delete(); done_sizes.delete();
    exp_perr.delete(); done_perr.delete(); done_cyc.delete(); rd_cyc.delete();
    reads = 0;
  endtask

  task automatic fill_pay(input int n);
    pay_q.delete();
    repeat (n) pay_q.push_back(8'($urandom));
  endtask

  // Reference: parity is the XOR of header and payload; a packet counts as bad when
  // the trailing byte differs from it.
  task automatic send_pkt(input logic [7:0] hdr, input bit force_par, input logic [7:0] par_byte);
    logic [7:0] par;
    bit perr;
    par = hdr;
    fifo.push_back(hdr);
    foreach (pay_q[i]) begin
      fifo.push_back(pay_q[i]);
      exp_bytes.push_back(pay_q[i]);
      par = par ^ pay_q[i];
    end
    perr = force_par && (par_byte != par);
    fifo.push_back(force_par ? par_byte : par);
    exp_sizes.push_back(exp_bytes.size());
    exp_perr.push_back(perr);
    exp_pkt = sat(exp_pkt);
    if (perr) exp_err = sat(exp_err);
  endtask

  task automatic wait_pkts(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (done_sizes.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_in_time"}, 32'(done_sizes.size()), 32'(n));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_pkts(input string tag);
    check({tag, "_nbytes"}, 32'(got.size()), 32'(exp_bytes.size()));
    foreach (exp_bytes[i])
      if (i < got.size()) check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_bytes[i]));
    check({tag, "_npkts"}, 32'(done_sizes.size()), 32'(exp_sizes.size()));
    foreach (exp_sizes[i])
      if (i < done_sizes.size()) begin
        check($sformatf("%s_len_at_done%0d", tag, i), 32'(done_sizes[i]), 32'(exp_sizes[i]));
        check($sformatf("%s_perr%0d", tag, i), 32'(done_perr[i]), 32'(exp_perr[i]));
      end
    check({tag, "_pkt_count"}, 32'(p.pkt_count), 32'(exp_pkt));
    check({tag, "_err_count"}, 32'(p.err_count), 32'(exp_err));
    check({tag, "_drop_count"}, 32'(p.drop_count), 32'(exp_drop));
    check({tag, "_stray_perr"}, 32'(stray_perr), 32'(0));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(p.busy), 32'(0));
    check({tag, "_rd_en"}, 32'(p.rd_en), 32'(0));
    check({tag, "_byte_valid"}, 32'(p.byte_valid), 32'(0));
    check({tag, "_pkt_done"}, 32'(p.pkt_done), 32'(0));
    check({tag, "_parity_err"}, 32'(p.parity_err), 32'(0));
    check({tag, "_byte_out"}, 32'(p.byte_out), 32'(0));
    check({tag, "_pkt_len"}, 32'(p.pkt_len), 32'(0));
    check({tag, "_pkt_count"}, 32'(p.pkt_count), 32'(0));
    check({tag, "_err_count"}, 32'(p.err_count), 32'(0));
    check({tag, "_drop_count"}, 32'(p.drop_count), 32'(0));
  endtask

  initial begin : main
    int t;
    int len;
    logic [7:0] hdr;
    rst = 1'b1;
    p.enable = 1'b1;
    p.rd_delay = 5'd0;
    p.soft_reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Known packet, good parity, latency from vld_out
    clear_obs();
    pay_q = {8'h11, 8'h22, 8'h33};
    send_pkt(8'h0D, 1'b1, 8'h0D);
    wait_pkts("t1", 1, 60);
    check_pkts("t1");
    check("t1_pkt_len", 32'(p.pkt_len), 32'd3);
    if (done_cyc.size() > 0) check("t1_done_latency", 32'(int'(done_cyc[0] - vld_rise_cyc)), 32'd9);
    if (rd_cyc.size() > 0) check("t1_hdr_rd_latency", 32'(int'(rd_cyc[0] - vld_rise_cyc)), 32'd2);
    check("t1_reads", 32'(reads), 32'd5);

    // Corrupted parity byte
    clear_obs();
    send_pkt(8'h0D, 1'b1, 8'h00);
    wait_pkts("t2", 1, 60);
    check_pkts("t2");

    // vld_out low for 4 cycles after the second payload read
    clear_obs();
    stall_at = 3;
    send_pkt(8'h0D, 1'b0, 8'h00);
    wait_pkts("t3", 1, 80);
    stall_at = -1;
    check_pkts("t3");
    check("t3_reads", 32'(reads), 32'd5);
    if (rd_cyc.size() == 5) begin
      check("t3_gap_p1_p2", 32'(int'(rd_cyc[2] - rd_cyc[1])), 32'd1);
      check("t3_gap_p2_p3", 32'(int'(rd_cyc[3] - rd_cyc[2])), 32'd5);
      check("t3_gap_p3_par", 32'(int'(rd_cyc[4] - rd_cyc[3])), 32'd1);
    end

    // enable low holds off a new packet
    clear_obs();
    p.enable = 1'b0;
    fill_pay(4);
    send_pkt({6'd4, 2'd2}, 1'b0, 8'h00);
    repeat (20) @(negedge clk);
    check("en_off_busy", 32'(p.busy), 32'd0);
    check("en_off_reads", 32'(reads), 32'd0);
    p.enable = 1'b1;
    wait_pkts("en_on", 1, 60);
    check_pkts("en_on");

    // soft_reset during a long DELAY
    clear_obs();
    p.rd_delay = 5'd31;
    fifo.push_back(8'h0D); fifo.push_back(8'h11); fifo.push_back(8'h22);
    fifo.push_back(8'h33); fifo.push_back(8'h0D);
    t = 0;
    while (p.busy !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    check("t4_busy", 32'(p.busy), 32'd1);
    repeat (5) @(negedge clk);
    p.soft_reset = 1'b1;
    fifo.delete();
    @(negedge clk);
    p.soft_reset = 1'b0;
    exp_drop = sat(exp_drop);
    check("t4_idle_next", 32'(p.busy), 32'd0);
    check("t4_drop_count", 32'(p.drop_count), 32'(exp_drop));
    check("t4_pkt_count", 32'(p.pkt_count), 32'(exp_pkt));
    repeat (40) @(negedge clk);
    check("t4_no_rd", 32'(reads), 32'd0);
    check("t4_no_done", 32'(done_sizes.size()), 32'd0);
    p.rd_delay = 5'd0;

    // len=63 then len=1 back to back
    clear_obs();
    fill_pay(63);
    send_pkt({6'd63, 2'd2}, 1'b0, 8'h00);
    fill_pay(1);
    send_pkt({6'd1, 2'd3}, 1'b0, 8'h00);
    wait_pkts("t5", 2, 300);
    check_pkts("t5");

    // Random packets, delays, parity corruption and vld_out gaps
    clear_obs();
    rand_stall = 1'b1;
    for (int k = 0; k < 10; k++) begin
      p.rd_delay = 5'($urandom_range(0, 6));
      len = $urandom_range(1, 24);
      fill_pay(len);
      send_pkt({6'(len), 2'($urandom_range(0, 3))}, ($urandom_range(0, 3) == 0), 8'($urandom));
      wait_pkts($sformatf("rnd%0d", k), k + 1, 400);
    end
    rand_stall = 1'b0;
    p.rd_delay = 5'd0;
    check_pkts("rnd");
    check("rd_en_without_vld", 32'(rd_viol), 32'd0);

    // Asynchronous rst in the middle of the payload
    clear_obs();
    fill_pay(20);
    fifo.push_back({6'd20, 2'd0});
    foreach (pay_q[i]) fifo.push_back(pay_q[i]);
    fifo.push_back(8'h00);
    t = 0;
    while (got.size() < 3 && t < 60) begin @(negedge clk); t++; end
    check("t6_mid_payload", 32'(got.size() >= 3), 32'd1);
    rst = 1'b1;
    fifo.delete();
    #1;
    check_reset_vals("t6_async");
    exp_pkt = 0; exp_err = 0; exp_drop = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_obs();
    fill_pay(5);
    send_pkt({6'd5, 2'd1}, 1'b0, 8'h00);
    wait_pkts("t6_after", 1, 60);
    check_pkts("t6_after");

    // Counter saturation: 260 bad one-byte packets
    clear_obs();
    for (int k = 0; k < 260; k++) begin
      fill_pay(1);
      hdr = {6'd1, 2'(k)};
      send_pkt(hdr, 1'b1, ~(hdr ^ pay_q[0]));
    end
    wait_pkts("sat", 260, 4000);
    check_pkts("sat");
    check("sat_pkt_max", 32'(p.pkt_count), 32'(CNT_MAX));
    check("sat_err_max", 32'(p.err_count), 32'(CNT_MAX));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
